// File: rtl/inst_fetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Instruction fetch front end. Issues sequential word-aligned fetch requests to
// instruction memory, buffers the in-order responses in a small FIFO together
// with their PCs, and presents one {pc, inst} per cycle to decode. A redirect
// from execute flushes the FIFO, restarts fetch at the new PC and arranges for
// every response still in flight to be discarded on arrival.
//
// Parameters:
//   QUEUE_DEPTH  FIFO entries and outstanding-request budget (power of 2, >= 2)
//   RESET_PC     first fetch address after reset
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   ireq_valid/ready/addr        fetch request channel to instruction memory
//   iresp_valid/inst             in-order, non-stallable response beats
//   out_valid/ready/pc/inst      instruction stream to decode
//   jump_valid/addr              redirect from execute (addr[1:0] ignored)
//
// Optional feature (macro FETCH_BYPASS_EN):
//   When defined, a response arriving while the FIFO is empty and nothing is
//   being dropped is presented to decode in the same cycle; if decode takes it,
//   it never enters the FIFO. When undefined, outputs are registered apart from
//   the jump_valid gating.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ireq_valid,
    input  logic        ireq_ready,
    output logic [31:0] ireq_addr,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    input  logic        jump_valid,
    input  logic [31:0] jump_addr
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 2;

    // Architectural state
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] ppc_head_q, ppc_head_d, ppc_tail_q, ppc_tail_d;
    // Low during reset and for the cycle in which reset is released, so that
    // no request is presented while the block is still held in reset.
    logic             run_q;

    // Storage: output FIFO of {pc, inst} and the PC FIFO of pending requests
    logic [31:0] pc_mem   [QUEUE_DEPTH];
    logic [31:0] inst_mem [QUEUE_DEPTH];
    logic [31:0] ppc_mem  [QUEUE_DEPTH];

    // Combinational helpers
    logic             accept;
    logic             resp_keep;
    logic             resp_drop;
    logic [31:0]      resp_pc;
    logic             bypass_hit;
    logic             fifo_push;
    logic             fifo_pop;
    logic [SUM_W-1:0] credit_sum;
    logic             jump_addr_unused;

    // The low address bits of a redirect target are deliberately discarded.
    assign jump_addr_unused = ^jump_addr[1:0];

    assign resp_drop = iresp_valid && (drop_q != '0);
    assign resp_keep = iresp_valid && (drop_q == '0);
    assign resp_pc   = ppc_mem[ppc_head_q];

    // Credit covers FIFO entries, requests in flight and responses still to be
    // discarded, so every kept response is guaranteed a free FIFO slot.
    assign credit_sum = SUM_W'(count_q) + SUM_W'(pend_q) + SUM_W'(drop_q);
    assign ireq_valid = run_q && !jump_valid && (credit_sum < SUM_W'(QUEUE_DEPTH));
    assign ireq_addr  = fetch_pc_q;
    assign accept     = ireq_valid && ireq_ready;

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = run_q && (count_q == '0) && (drop_q == '0) && !jump_valid && iresp_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        out_valid = ((count_q != '0) || bypass_hit) && !jump_valid;
        out_pc    = '0;
        out_inst  = '0;
        if (bypass_hit) begin
            out_pc   = resp_pc;
            out_inst = iresp_inst;
        end else if (count_q != '0) begin
            out_pc   = pc_mem[head_q];
            out_inst = inst_mem[head_q];
        end
    end

    // A bypassed response that decode takes this cycle never enters the FIFO;
    // bypass_hit implies an empty FIFO, so fifo_pop only ever pops a real entry.
    assign fifo_push = resp_keep && !jump_valid && !(bypass_hit && out_ready);
    assign fifo_pop  = out_valid && out_ready && (count_q != '0);

    // NOTE: every *_d gets its hold value first, so no path leaves a variable
    // unassigned and no latch can be inferred.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        pend_d     = pend_q;
        drop_d     = drop_q;
        ppc_head_d = ppc_head_q;
        ppc_tail_d = ppc_tail_q;

        if (jump_valid) begin
            // Redirect wins: flush the FIFO, turn every pending request into a
            // pending drop (less one if its response is arriving right now).
            head_d     = tail_q;
            count_d    = '0;
            fetch_pc_d = {jump_addr[31:2], 2'b00};
            drop_d     = drop_q + pend_q - CNT_W'(iresp_valid);
            pend_d     = '0;
            ppc_head_d = ppc_tail_q;
        end else begin
            if (accept) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                ppc_tail_d = ppc_tail_q + 1'b1;
            end
            if (resp_drop) begin
                drop_d = drop_q - 1'b1;
            end
            if (resp_keep) begin
                ppc_head_d = ppc_head_q + 1'b1;
            end
            if (fifo_push) begin
                tail_d = tail_q + 1'b1;
            end
            if (fifo_pop) begin
                head_d = head_q + 1'b1;
            end
            pend_d  = pend_q + CNT_W'(accept) - CNT_W'(resp_keep);
            count_d = count_q + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            pend_q     <= '0;
            drop_q     <= '0;
            ppc_head_q <= '0;
            ppc_tail_q <= '0;
            run_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            pend_q     <= pend_d;
            drop_q     <= drop_d;
            ppc_head_q <= ppc_head_d;
            ppc_tail_q <= ppc_tail_d;
            run_q      <= 1'b1;
        end
    end

    // NOTE: the storage arrays are not reset; an entry is only read once
    // count/pend say it was written, and outputs are forced to zero when empty.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            pc_mem[tail_q]   <= resp_pc;
            inst_mem[tail_q] <= iresp_inst;
        end
        if (accept) begin
            ppc_mem[ppc_tail_q] <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//
// Directed bench for inst_fetch_queue with an in-order instruction memory of
// configurable latency. Instruction words are a fixed scramble of their address
// so every decoded {pc, inst} pair can be cross-checked.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        ireq_valid;
    logic        ireq_ready;
    logic [31:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        jump_valid;
    logic [31:0] jump_addr;

    inst_fetch_queue #(
        .QUEUE_DEPTH (4),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ireq_valid  (ireq_valid),
        .ireq_ready  (ireq_ready),
        .ireq_addr   (ireq_addr),
        .iresp_valid (iresp_valid),
        .iresp_inst  (iresp_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .jump_valid  (jump_valid),
        .jump_addr   (jump_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;
    int cyc;
    int mem_lat;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] req_log[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_inst[$];

    typedef struct {
        logic        mem_rdy;
        logic        out_rdy;
        logic        jmp;
        logic [31:0] jaddr;
        logic        e_req_v;
        logic [31:0] e_req_a;
        logic        e_out_v;
        logic [31:0] e_out_pc;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // One clock cycle: record handshakes, advance, then drive the memory reply.
    task automatic step();
        mreq_t r;
        #1;
        if (ireq_valid && ireq_ready) begin
            r.due  = cyc + mem_lat;
            r.addr = ireq_addr;
            mem_q.push_back(r);
            req_log.push_back(ireq_addr);
        end
        if (out_valid && out_ready) begin
            pop_pc.push_back(out_pc);
            pop_inst.push_back(out_inst);
        end
        @(posedge clk);
        #1;
        cyc++;
        iresp_valid = 1'b0;
        iresp_inst  = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            iresp_valid = 1'b1;
            iresp_inst  = inst_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_pc.delete();
        pop_inst.delete();
    endtask

    // Asserts reset (memory side reset with it), checks outputs react at once,
    // then releases reset mid-cycle; the caller is left in cycle 0.
    task automatic do_reset(input string tag);
        reset_n     = 1'b0;
        iresp_valid = 1'b0;
        iresp_inst  = '0;
        jump_valid  = 1'b0;
        jump_addr   = '0;
        mem_q.delete();
        clear_logs();
        #1;
        check({tag, ".rst_ireq_valid"}, 32'(ireq_valid), 32'd0);
        check({tag, ".rst_out_valid"},  32'(out_valid),  32'd0);
        check({tag, ".rst_out_pc"},     out_pc,          32'd0);
        check({tag, ".rst_out_inst"},   out_inst,        32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cyc        = 0;
        mem_lat    = 1;
        reset_n    = 1'b1;
        ireq_ready = 1'b1;
        out_ready  = 1'b1;
        iresp_valid = 1'b0;
        iresp_inst = '0;
        jump_valid = 1'b0;
        jump_addr  = '0;

        // Cycle-by-cycle vectors, memory latency 1, decode always ready.
        // Index i is cycle i+1 after reset release. Redirect to 0x1003 in
        // cycle 7 coincides with the response for 0x14 while pend == 1.
        //            mem  out  jmp  jaddr         reqv  reqa          outv  out_pc
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0000, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0004, BYP,  32'h0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0008, 1'b1, BYP ? 32'h4 : 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_000C, 1'b1, BYP ? 32'h8 : 32'h4};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0010, 1'b1, BYP ? 32'hC : 32'h8};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0014, 1'b1, BYP ? 32'h10 : 32'hC};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h1003,   1'b0, 32'h0,         1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_1000, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_1004, BYP,  32'h1000};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_1008, 1'b1, BYP ? 32'h1004 : 32'h1000};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_100C, 1'b1, BYP ? 32'h1008 : 32'h1004};

        #2;
        // ---------------- A: streaming table, latency 1 ----------------
        mem_lat = 1;
        do_reset("A");
        step();
        for (int i = 0; i < 11; i++) begin
            ireq_ready = vecs[i].mem_rdy;
            out_ready  = vecs[i].out_rdy;
            jump_valid = vecs[i].jmp;
            jump_addr  = vecs[i].jaddr;
            #1;
            check($sformatf("A.c%0d.ireq_valid", i + 1), 32'(ireq_valid), 32'(vecs[i].e_req_v));
            if (vecs[i].e_req_v)
                check($sformatf("A.c%0d.ireq_addr", i + 1), ireq_addr, vecs[i].e_req_a);
            check($sformatf("A.c%0d.out_valid", i + 1), 32'(out_valid), 32'(vecs[i].e_out_v));
            if (vecs[i].e_out_v) begin
                check($sformatf("A.c%0d.out_pc", i + 1), out_pc, vecs[i].e_out_pc);
                check($sformatf("A.c%0d.out_inst", i + 1), out_inst, inst_of(vecs[i].e_out_pc));
            end
            step();
        end
        jump_valid = 1'b0;

        // ---------------- B: decode stalled, FIFO fills ----------------
        mem_lat    = 1;
        ireq_ready = 1'b1;
        out_ready  = 1'b0;
        do_reset("B");
        repeat (8) step();
        #1;
        check("B.req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (req_log.size() > i)
                check($sformatf("B.req%0d_addr", i), req_log[i], 32'(4 * i));
        check("B.full_ireq_valid", 32'(ireq_valid), 32'd0);
        check("B.full_out_valid",  32'(out_valid),  32'd1);
        check("B.full_out_pc",     out_pc,          32'd0);
        out_ready = 1'b1;
        repeat (6) step();
        check("B.pop_count_ge4", 32'(pop_pc.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++)
            if (pop_pc.size() > i) begin
                check($sformatf("B.pop%0d_pc", i), pop_pc[i], 32'(4 * i));
                check($sformatf("B.pop%0d_inst", i), pop_inst[i], inst_of(32'(4 * i)));
            end

        // ---------------- C: latency 3, redirect with 2 pending ----------------
        mem_lat    = 3;
        out_ready  = 1'b1;
        do_reset("C");
        repeat (3) step();               // now in cycle 3: requests 0x0, 0x4 pending
        check("C.pending_before_jump", 32'(req_log.size()), 32'd2);
        jump_valid = 1'b1;
        jump_addr  = 32'h0000_1003;
        #1;
        check("C.jump_ireq_valid", 32'(ireq_valid), 32'd0);
        check("C.jump_out_valid",  32'(out_valid),  32'd0);
        step();
        jump_valid = 1'b0;
        clear_logs();
        for (int k = 0; k < 20 && pop_pc.size() == 0; k++)
            step();
        check("C.first_req", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'h0000_1000);
        check("C.first_pop_pc", (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx, 32'h0000_1000);
        check("C.first_pop_inst", (pop_inst.size() > 0) ? pop_inst[0] : 32'hxxxx_xxxx,
              inst_of(32'h0000_1000));

        // ---------------- D: fetch_pc wraps past 0xFFFF_FFFC ----------------
        jump_valid = 1'b1;
        jump_addr  = 32'hFFFF_FFFE;
        step();
        jump_valid = 1'b0;
        mem_lat    = 1;
        clear_logs();
        for (int k = 0; k < 20 && pop_pc.size() < 2; k++)
            step();
        check("D.req0", (req_log.size() > 0) ? req_log[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        check("D.req1", (req_log.size() > 1) ? req_log[1] : 32'hxxxx_xxxx, 32'h0000_0000);
        check("D.pop0_pc", (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx, 32'hFFFF_FFFC);
        check("D.pop1_pc", (pop_pc.size() > 1) ? pop_pc[1] : 32'hxxxx_xxxx, 32'h0000_0000);

        // ---------------- E: reset pulsed mid-stream ----------------
        repeat (3) step();
        #1;
        check("E.pre_out_valid", 32'(out_valid), 32'd1);
        do_reset("E");
        step();
        #1;
        check("E.restart_ireq_valid", 32'(ireq_valid), 32'd1);
        check("E.restart_ireq_addr",  ireq_addr,       32'h0000_0000);
        clear_logs();
        for (int k = 0; k < 20 && pop_pc.size() == 0; k++)
            step();
        check("E.first_pop_pc", (pop_pc.size() > 0) ? pop_pc[0] : 32'hxxxx_xxxx, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

- Instruction fetch front end that produces the `Inst`/PC stream consumed by the decode stage.
- Issues sequential 32-bit fetch requests to instruction memory and buffers in-order responses in a small FIFO.
- Presents one instruction per cycle to decode over a valid/ready handshake.
- On a redirect from execute (branch/jump/trap), restarts at a new PC and discards every stale in-flight response.

## Interface
- `QUEUE_DEPTH`, default 4: FIFO entries, which is also the outstanding-request budget. Must be a power of 2, ≥2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ireq_valid` out 1: fetch request valid.
- `ireq_ready` in 1: memory accepts the request this cycle.
- `ireq_addr` out 32: fetch address, always word-aligned.
- `iresp_valid` in 1: response beat. Responses arrive in order, at least 1 cycle after acceptance, and cannot be stalled.
- `iresp_inst` in 32: fetched instruction word.
- `out_valid` out 1: instruction available to decode.
- `out_ready` in 1: decode consumes the head this cycle.
- `out_pc` out 32: PC of the head instruction.
- `out_inst` out 32 (`Inst`): head instruction word.
- `jump_valid` in 1: redirect request.
- `jump_addr` in 32: redirect target. Bits [1:0] are ignored and forced to 0.

## Operation
State registers:
- `fetch_pc`: next address to request.
- FIFO of {pc, inst}, with `head`, `tail` and `count`.
- `pend`: accepted requests whose responses have not yet arrived.
- `drop`: responses still to be discarded.
- `pend` and `drop` are each `$clog2(QUEUE_DEPTH)+1` bits wide.
- A PC FIFO holds the address of each pending request, so the response pairs with its own PC.

Request issue:
- `ireq_valid = !jump_valid && (count + pend + drop < QUEUE_DEPTH)`, with `ireq_addr = fetch_pc`.
- On accept (`ireq_valid && ireq_ready`): `fetch_pc += 4`, wrapping modulo 2^32; `pend += 1`.
- `ireq_valid` is not sticky. Memory samples the request only on valid&&ready.

Response handling:
- `iresp_valid` with `drop > 0`: `drop -= 1` and the data is discarded.
- Otherwise: `pend -= 1`, and {pend PC, `iresp_inst`} is written at the tail.
- FIFO overflow cannot occur, because of the credit rule.

Output:
- `out_valid = (count != 0) && !jump_valid`, carrying the head entry.
- Pop on `out_valid && out_ready`.

Redirect (`jump_valid`), takes priority over everything else:
- FIFO cleared: `count = 0`, `head = tail`.
- `fetch_pc = {jump_addr[31:2], 2'b00}`.
- `drop = drop + pend − (iresp_valid ? 1 : 0)`, then `pend = 0`.
- A response arriving in the redirect cycle is discarded.
- No request is issued and no pop occurs in that cycle.

Simultaneous events:
- Accept, response and pop in the same cycle all apply, and the counters update by net delta.
- A pop and a write when `count == QUEUE_DEPTH−1` is legal.

Reset values (while `reset_n` = 0):
- `fetch_pc = RESET_PC`; `count`, `pend`, `drop` = 0.
- `out_valid = 0`, `out_pc = 0`, `out_inst = 0`.
- `ireq_valid = 0`.
- Asserting reset mid-operation abandons all in-flight requests. The memory side must be reset together with this block.

## Timing
- First `ireq_valid` in the first cycle after `reset_n` deasserts.
- Response-to-`out_valid` latency: 1 cycle (registered FIFO).
- Redirect-to-first-request latency: the first request with the new PC is issued in the cycle after `jump_valid`, if credit allows.
- Sustained throughput: 1 instr/cycle when memory latency L ≤ QUEUE_DEPTH−1.
- `out_valid`/`ireq_valid` depend combinationally on `jump_valid`. There is no other input→output combinational path, except as stated under Configuration.

## Configuration
`FETCH_BYPASS_EN`:
- Defined: when `count == 0`, `drop == 0`, `!jump_valid` and `iresp_valid`, the response drives `out_valid`/`out_pc`/`out_inst` in the same cycle (0-cycle latency).
  - If `out_ready`, the response is consumed without entering the FIFO.
  - Otherwise it is written to the FIFO as normal.
- Undefined: always 1-cycle latency, and outputs are purely registered except for the `jump_valid` gating.

## Test plan
- Reset, memory latency 1, `out_ready`=1 → requests 0x0, 0x4, 0x8…. `out_pc` 0x0 appears in cycle 3 (cycle 2 with bypass), then one instruction per cycle.
- `out_ready`=0, memory always ready → exactly 4 requests (0x0–0xC), then `ireq_valid`=0. FIFO holds 4 entries. Releasing `out_ready` yields 0x0, 0x4, 0x8, 0xC in order.
- Memory latency 3, `jump_valid` with `jump_addr`=0x1003 while 2 requests are pending → those 2 responses are dropped. Next request is 0x1000, and the first `out_pc` after the redirect is 0x1000.
- Redirect in the same cycle as a response, with `pend`=1 → the response is discarded, `drop` ends at 0, and no stale instruction reaches decode.
- `fetch_pc`=0xFFFF_FFFC → next request 0x0000_0000.
- `reset_n` pulsed low mid-stream → all outputs return to reset values immediately, and fetch restarts at `RESET_PC`.
